md_sched: RTL

- Multiply/divide scheduler for the 32-bit MIPS core.
- Sits in EX and owns the HI/LO registers. It sequences a pipelined multiplier and an iterative radix-2 divider.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the decode controls with a valid/ready handshake. Stalls the pipeline while a HI/LO result is outstanding.

---
 rtl/md_pkg.sv | 22 ++
 rtl/md_div_iter.sv | 68 ++++++
 rtl/md_sched.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide scheduler: op codes, FSM states,
// divider iteration count and a signed-magnitude helper.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;
  localparam logic [2:0] MD_MFHI  = 3'b110;
  localparam logic [2:0] MD_MFLO  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} md_state_e;

  localparam int DIV_ITERS = 32;

  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_div_iter.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle over
// DIV_ITERS cycles; quotient/remainder are presented during the final cycle.
module div_iter
  import md_pkg::*;
#(
  parameter logic [31:0] ZERO_DIV_Q = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  input  logic        i_kill,
  output logic        o_done,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem
);

  logic [5:0]  r_cnt;
  logic [63:0] r_rem_p0;
  logic [31:0] r_dvs_p0;
  logic [31:0] r_src1_p0;
  logic        r_qneg_p0;
  logic        r_rneg_p0;
  logic        r_zero_p0;

  logic [64:0] w_sh;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [63:0] w_next;

  // The shifted partial remainder can reach 33 bits, so compare on 33 bits.
  always_comb begin
    w_sh   = {r_rem_p0, 1'b0};
    w_diff = w_sh[64:32] - {1'b0, r_dvs_p0};
    w_ge   = ~w_diff[32];
    w_next = {(w_ge ? w_diff[31:0] : w_sh[63:32]), w_sh[31:1], w_ge};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             r_cnt <= '0;
    else if (i_kill)         r_cnt <= '0;
    else if (i_start)        r_cnt <= 6'(DIV_ITERS);
    else if (r_cnt != 6'd0)  r_cnt <= r_cnt - 6'd1;
  end

  // Operand latch (stage p0) and per-iteration partial remainder update.
  always_ff @(posedge clk) begin
    if (i_start) begin
      r_rem_p0  <= {32'd0, md_abs(i_dividend, i_signed)};
      r_dvs_p0  <= md_abs(i_divisor, i_signed);
      r_src1_p0 <= i_dividend;
      r_qneg_p0 <= i_signed & (i_dividend[31] ^ i_divisor[31]);
      r_rneg_p0 <= i_signed & i_dividend[31];
      r_zero_p0 <= (i_divisor == 32'd0);
    end else if (r_cnt != 6'd0) begin
      r_rem_p0  <= w_next;
    end
  end

  assign o_done = (r_cnt == 6'd1) & ~i_kill;
  assign o_quot = r_zero_p0 ? ZERO_DIV_Q :
                  (r_qneg_p0 ? (~w_next[31:0] + 32'd1) : w_next[31:0]);
  assign o_rem  = r_zero_p0 ? r_src1_p0 :
                  (r_rneg_p0 ? (~w_next[63:32] + 32'd1) : w_next[63:32]);

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler owning HI/LO. Optional MFHI/MFLO bypass in the
// last busy cycle is enabled by defining MD_FWD_EN.
module md_sched
  import md_pkg::*;
#(
  parameter int          MUL_LAT    = 2,
  parameter logic [31:0] ZERO_DIV_Q = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        md_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_src1,
  input  logic [31:0] md_src2,
  input  logic        md_flush,
  output logic        md_ready,
  output logic [31:0] md_rdata,
  output logic        md_busy,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  md_state_e   r_state;
  logic        r_busy;
  logic [2:0]  r_mcnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] r_prod_p0;

  logic        w_acc;
  logic        w_rd_op;
  logic        w_mul_op;
  logic        w_div_op;
  logic        w_msgn;
  logic signed [63:0] w_a;
  logic signed [63:0] w_b;
  logic signed [63:0] w_prod;
  logic        w_mul_last;
  logic        w_div_done;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_new_hi;
  logic [31:0] w_new_lo;
  logic        w_last;
  logic [31:0] w_hi_rd;
  logic [31:0] w_lo_rd;

  assign w_acc    = md_valid & md_ready & ~md_flush;
  assign w_rd_op  = (md_op == MD_MFHI) || (md_op == MD_MFLO);
  assign w_mul_op = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign w_div_op = (md_op == MD_DIV)  || (md_op == MD_DIVU);

  // Sign- or zero-extend to 64 bits; the low 64 product bits are then exact.
  assign w_msgn = (md_op == MD_MULT);
  assign w_a    = {{32{w_msgn & md_src1[31]}}, md_src1};
  assign w_b    = {{32{w_msgn & md_src2[31]}}, md_src2};
  assign w_prod = w_a * w_b;

  div_iter #(.ZERO_DIV_Q(ZERO_DIV_Q)) u_div (
    .clk        (clk),
    .resetn     (resetn),
    .i_start    (w_acc & w_div_op),
    .i_signed   (md_op == MD_DIV),
    .i_dividend (md_src1),
    .i_divisor  (md_src2),
    .i_kill     (md_flush),
    .o_done     (w_div_done),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  assign w_mul_last = (r_state == S_MUL) && (r_mcnt == 3'd1);
  assign w_new_hi   = (r_state == S_MUL) ? r_prod_p0[63:32] : w_rem;
  assign w_new_lo   = (r_state == S_MUL) ? r_prod_p0[31:0]  : w_quot;

`ifdef MD_FWD_EN
  assign w_last = w_mul_last || ((r_state == S_DIV) && w_div_done);
`else
  assign w_last = 1'b0;
`endif

  assign md_ready = (r_state == S_IDLE) || (w_last && w_rd_op);
  assign w_hi_rd  = w_last ? w_new_hi : r_hi;
  assign w_lo_rd  = w_last ? w_new_lo : r_lo;
  assign md_rdata = !md_valid            ? 32'd0   :
                    (md_op == MD_MFHI)   ? w_hi_rd :
                    (md_op == MD_MFLO)   ? w_lo_rd : 32'd0;

  // Multiplier stage p0: product captured at the handshake edge.
  always_ff @(posedge clk) begin
    if (w_acc && w_mul_op) r_prod_p0 <= w_prod;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_mcnt  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            if (w_mul_op) begin
              if (MUL_LAT == 1) begin
                r_hi <= w_prod[63:32];
                r_lo <= w_prod[31:0];
              end else begin
                r_mcnt  <= 3'(MUL_LAT - 1);
                r_state <= S_MUL;
                r_busy  <= 1'b1;
              end
            end else if (w_div_op) begin
              r_state <= S_DIV;
              r_busy  <= 1'b1;
            end else if (md_op == MD_MTHI) begin
              r_hi <= md_src1;
            end else if (md_op == MD_MTLO) begin
              r_lo <= md_src1;
            end
          end
        end
        S_MUL: begin
          if (md_flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_mul_last) begin
            r_hi    <= w_new_hi;
            r_lo    <= w_new_lo;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_mcnt  <= r_mcnt - 3'd1;
          end
        end
        S_DIV: begin
          if (md_flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_div_done) begin
            r_hi    <= w_new_hi;
            r_lo    <= w_new_lo;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign md_busy = r_busy;
  assign hi_q    = r_hi;
  assign lo_q    = r_lo;

endmodule
